// File: rtl/enc_16x4_scan_pkg.sv
// Shared widths, FSM encoding and picker helpers for the 16x4 scan encoder
// and any sibling encoder/decoder pairs.
package enc_16x4_scan_pkg;

  localparam int VEC_W  = 16;
  localparam int CODE_W = 4;
  localparam int HALF_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    ZERO = 2'd2
  } state_e;

  // True when exactly one bit of v is set (popcount == 1).
  function automatic logic is_pop1(input logic [VEC_W-1:0] v);
    return (v != '0) && ((v & (v - VEC_W'(1))) == '0);
  endfunction

  // 8x3 priority picker: lowest set index, or highest when msb_first.
  function automatic logic [2:0] pick8(input logic [HALF_W-1:0] v, input logic msb_first);
    logic [2:0] c;
    c = '0;
    if (msb_first) begin
      for (int i = 0; i < HALF_W; i++) if (v[i]) c = 3'(i);
    end else begin
      for (int i = HALF_W-1; i >= 0; i--) if (v[i]) c = 3'(i);
    end
    return c;
  endfunction

endpackage

// File: rtl/pri_pick_16x4.sv
// Combinational 16x4 priority picker built from two 8x3 halves; the half
// select bit becomes the code MSB.
module pri_pick_16x4
  import enc_16x4_scan_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic [VEC_W-1:0]  mask_i,
  output logic [CODE_W-1:0] code_o,
  output logic              any_o,
  output logic              single_o
);

  logic       lo_any, hi_any, sel_hi;
  logic [2:0] lo_code, hi_code;

  assign lo_any  = |mask_i[HALF_W-1:0];
  assign hi_any  = |mask_i[VEC_W-1:HALF_W];
  assign lo_code = pick8(mask_i[HALF_W-1:0], MSB_FIRST);
  assign hi_code = pick8(mask_i[VEC_W-1:HALF_W], MSB_FIRST);

  // Upper half wins when scanning downward and it has a bit, or when
  // scanning upward and the lower half is empty.
  assign sel_hi   = MSB_FIRST ? hi_any : !lo_any;
  assign code_o   = {sel_hi, sel_hi ? hi_code : lo_code};
  assign any_o    = lo_any | hi_any;
  assign single_o = is_pop1(mask_i);

endmodule

// File: rtl/enc_16x4_scan.sv
// Sequential 16-to-4 encoder: accepts a request vector and emits the index of
// each set bit, one registered beat per cycle, in priority order.
module enc_16x4_scan
  import enc_16x4_scan_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0,
  parameter bit ZERO_BEAT = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [VEC_W-1:0]  in_D,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic              out_last,
  output logic              out_zero
);

  state_e              state_q;
  logic [VEC_W-1:0]    mask_q;
  logic                in_ready_q, out_valid_q, out_last_q, out_zero_q;
  logic [CODE_W-1:0]   out_code_q;

  logic                beat_acc;
  logic [VEC_W-1:0]    mask_clr, pick_in;
  logic [CODE_W-1:0]   pk_code;
  logic                pk_any, pk_single;

  // In IDLE the picker looks at in_D so the zero test needs no extra logic;
  // during a scan it looks ahead at the mask left after the current beat.
  always_comb begin
    beat_acc = out_valid_q && out_ready;
    mask_clr = mask_q & ~(VEC_W'(1) << out_code_q);
    if (state_q == IDLE) pick_in = in_D;
    else                 pick_in = beat_acc ? mask_clr : mask_q;
  end

  pri_pick_16x4 #(.MSB_FIRST(MSB_FIRST)) u_pick (
    .mask_i   (pick_in),
    .code_o   (pk_code),
    .any_o    (pk_any),
    .single_o (pk_single)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mask_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_code_q  <= '0;
      out_last_q  <= 1'b0;
      out_zero_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          out_valid_q <= 1'b0;
          if (in_valid && in_ready_q) begin
            mask_q <= in_D;
            if (pk_any) begin
              state_q    <= SCAN;
              in_ready_q <= 1'b0;
            end else if (ZERO_BEAT) begin
              state_q    <= ZERO;
              in_ready_q <= 1'b0;
            end
          end
        end
        SCAN: begin
          if (beat_acc) mask_q <= mask_clr;
          if (beat_acc && out_last_q) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
          end else begin
            // Under backpressure this reloads the same pick of an unchanged mask.
            out_valid_q <= 1'b1;
            out_code_q  <= pk_code;
            out_last_q  <= pk_single;
            out_zero_q  <= 1'b0;
          end
        end
        ZERO: begin
          if (beat_acc) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_zero_q  <= 1'b0;
          end else begin
            out_valid_q <= 1'b1;
            out_code_q  <= '0;
            out_last_q  <= 1'b1;
            out_zero_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_code  = out_code_q;
  assign out_last  = out_last_q;
  assign out_zero  = out_zero_q;

endmodule

// File: tb/tb_enc_16x4_scan.sv
// Bench for enc_16x4_scan: directed scenarios plus randomized traffic against
// a remaining-bits reference model, on an LSB-first and an MSB-first instance.
module tb_enc_16x4_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] in_D = '0;

  logic       a_in_ready, a_out_valid, a_out_last, a_out_zero;
  logic [3:0] a_out_code;
  logic       b_in_ready, b_out_valid, b_out_last, b_out_zero;
  logic [3:0] b_out_code;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  enc_16x4_scan #(.MSB_FIRST(1'b0), .ZERO_BEAT(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready), .in_D(in_D),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_code(a_out_code),
    .out_last(a_out_last), .out_zero(a_out_zero));

  enc_16x4_scan #(.MSB_FIRST(1'b1), .ZERO_BEAT(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready), .in_D(in_D),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_code(b_out_code),
    .out_last(b_out_last), .out_zero(b_out_zero));

  // Reference model: bits still to emit, pending zero beat, one-cycle bubble after capture.
  logic [15:0] rem [2];
  bit          zp  [2];
  bit          bub [2];

  function automatic int nxt_code(int d);
    if (zp[d]) return 0;
    if (d == 0) begin
      for (int i = 0; i < 16; i++) if (rem[d][i]) return i;
    end else begin
      for (int i = 15; i >= 0; i--) if (rem[d][i]) return i;
    end
    return 0;
  endfunction

  function automatic logic [7:0] mk(bit v, bit r, int c, bit l, bit z);
    return v ? {1'b1, r, 4'(c), l, z} : {1'b0, r, 6'b0};
  endfunction

  function automatic logic [7:0] exp_vec(int d);
    bit busy;
    busy = (rem[d] != 0) || zp[d];
    return mk(busy && !bub[d], !busy && !bub[d], nxt_code(d),
              zp[d] || ($countones(rem[d]) == 1), zp[d]);
  endfunction

  function automatic logic [7:0] obs_vec(int d);
    if (d == 0) return mk(a_out_valid, a_in_ready, int'(a_out_code), a_out_last, a_out_zero);
    return mk(b_out_valid, b_in_ready, int'(b_out_code), b_out_last, b_out_zero);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        rem[d] <= '0;
        zp[d]  <= 1'b0;
        bub[d] <= 1'b0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (bub[d]) bub[d] <= 1'b0;
        else if (rem[d] != 0 || zp[d]) begin
          if (out_ready) begin
            if (zp[d]) zp[d] <= 1'b0;
            else       rem[d] <= rem[d] & ~(16'd1 << nxt_code(d));
          end
        end else if (in_valid) begin
          if (in_D != 0) begin
            rem[d] <= in_D;
            bub[d] <= 1'b1;
          end else if (d == 0) begin
            zp[d]  <= 1'b1;
            bub[d] <= 1'b1;
          end
        end
      end
    end
  end

  // Recorder: cycle i shows the outputs after edge i (vector presented at edge 0).
  logic [7:0] ra [32];
  logic [7:0] rb [32];
  logic [7:0] ea [32];
  logic [7:0] eb [32];

  task automatic collect(input logic [15:0] v, input int n, input logic [31:0] pat, input int inj);
    for (int i = 0; i < n; i++) begin
      out_ready = pat[i];
      in_valid  = (i == 0) || (i == inj);
      in_D      = (i == inj) ? 16'hFFFF : v;
      @(negedge clk);
      ra[i] = obs_vec(0);
      rb[i] = obs_vec(1);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({a_out_valid, a_in_ready, a_out_code, a_out_last, a_out_zero} !== 8'b0100_0000) begin
      bad++;
      $display("FAIL reset_a got=%b exp=01000000", {a_out_valid, a_in_ready, a_out_code, a_out_last, a_out_zero});
    end
    total++;
    if ({b_out_valid, b_in_ready, b_out_code, b_out_last, b_out_zero} !== 8'b0100_0000) begin
      bad++;
      $display("FAIL reset_b got=%b exp=01000000", {b_out_valid, b_in_ready, b_out_code, b_out_last, b_out_zero});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single;
    collect(16'h0001, 4, '1, -1);
    ea[0] = mk(0,0,0,0,0); ea[1] = mk(1,0,0,1,0); ea[2] = mk(0,1,0,0,0); ea[3] = mk(0,1,0,0,0);
    for (int i = 0; i < 4; i++) begin
      total += 2;
      if (ra[i] !== ea[i]) begin bad++; $display("FAIL single_a cyc=%0d got=%h exp=%h", i, ra[i], ea[i]); end
      if (rb[i] !== ea[i]) begin bad++; $display("FAIL single_b cyc=%0d got=%h exp=%h", i, rb[i], ea[i]); end
    end
  endtask

  task automatic test_multibit;
    collect(16'h8421, 7, '1, -1);
    ea[0] = mk(0,0,0,0,0);  eb[0] = ea[0];
    ea[1] = mk(1,0,0,0,0);  eb[1] = mk(1,0,15,0,0);
    ea[2] = mk(1,0,5,0,0);  eb[2] = mk(1,0,10,0,0);
    ea[3] = mk(1,0,10,0,0); eb[3] = mk(1,0,5,0,0);
    ea[4] = mk(1,0,15,1,0); eb[4] = mk(1,0,0,1,0);
    ea[5] = mk(0,1,0,0,0);  eb[5] = ea[5];
    ea[6] = ea[5];          eb[6] = ea[5];
    for (int i = 0; i < 7; i++) begin
      total += 2;
      if (ra[i] !== ea[i]) begin bad++; $display("FAIL multi_a cyc=%0d got=%h exp=%h", i, ra[i], ea[i]); end
      if (rb[i] !== eb[i]) begin bad++; $display("FAIL multi_b cyc=%0d got=%h exp=%h", i, rb[i], eb[i]); end
    end
  endtask

  task automatic test_backpressure;
    // out_ready low at edges 2..4, FFFF pulse on in_valid at edge 3.
    collect(16'h0110, 9, 32'hFFFF_FFE3, 3);
    ea[0] = mk(0,0,0,0,0); eb[0] = ea[0];
    for (int i = 1; i <= 4; i++) begin ea[i] = mk(1,0,4,0,0); eb[i] = mk(1,0,8,0,0); end
    ea[5] = mk(1,0,8,1,0); eb[5] = mk(1,0,4,1,0);
    for (int i = 6; i < 9; i++) begin ea[i] = mk(0,1,0,0,0); eb[i] = ea[i]; end
    for (int i = 0; i < 9; i++) begin
      total += 2;
      if (ra[i] !== ea[i]) begin bad++; $display("FAIL bp_a cyc=%0d got=%h exp=%h", i, ra[i], ea[i]); end
      if (rb[i] !== eb[i]) begin bad++; $display("FAIL bp_b cyc=%0d got=%h exp=%h", i, rb[i], eb[i]); end
    end
  endtask

  task automatic test_zero;
    collect(16'h0000, 4, '1, -1);
    ea[0] = mk(0,0,0,0,0); ea[1] = mk(1,0,0,1,1); ea[2] = mk(0,1,0,0,0); ea[3] = ea[2];
    for (int i = 0; i < 4; i++) begin
      eb[i] = mk(0,1,0,0,0);
      total += 2;
      if (ra[i] !== ea[i]) begin bad++; $display("FAIL zero_a cyc=%0d got=%h exp=%h", i, ra[i], ea[i]); end
      if (rb[i] !== eb[i]) begin bad++; $display("FAIL zero_b cyc=%0d got=%h exp=%h", i, rb[i], eb[i]); end
    end
  endtask

  task automatic test_reset_loopback;
    logic [15:0] acc [2];
    int          cnt [2];
    int          lastcyc [2];
    collect(16'hFFFF, 4, '1, -1);
    total += 2;
    if (ra[3] !== mk(1,0,2,0,0)) begin bad++; $display("FAIL midscan_a got=%h exp=%h", ra[3], mk(1,0,2,0,0)); end
    if (rb[3] !== mk(1,0,13,0,0)) begin bad++; $display("FAIL midscan_b got=%h exp=%h", rb[3], mk(1,0,13,0,0)); end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({a_out_valid, a_in_ready, b_out_valid, b_in_ready} !== 4'b0101) begin
      bad++;
      $display("FAIL async_reset got=%b exp=0101", {a_out_valid, a_in_ready, b_out_valid, b_in_ready});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({a_out_valid, a_in_ready, b_out_valid, b_in_ready} !== 4'b0101) begin
      bad++;
      $display("FAIL no_resume got=%b exp=0101", {a_out_valid, a_in_ready, b_out_valid, b_in_ready});
    end
    collect(16'hFFFF, 20, '1, -1);
    for (int d = 0; d < 2; d++) begin
      acc[d] = '0; cnt[d] = 0; lastcyc[d] = -1;
      for (int i = 0; i < 20; i++) begin
        logic [7:0] r;
        r = (d == 0) ? ra[i] : rb[i];
        if (r[7]) begin
          acc[d] = acc[d] | (16'd1 << r[5:2]);
          cnt[d]++;
          if (r[1]) lastcyc[d] = i;
        end
      end
      total += 3;
      if (acc[d] !== 16'hFFFF) begin bad++; $display("FAIL loop_or d=%0d got=%h exp=ffff", d, acc[d]); end
      if (cnt[d] != 16) begin bad++; $display("FAIL loop_cnt d=%0d got=%0d exp=16", d, cnt[d]); end
      if (lastcyc[d] != 16) begin bad++; $display("FAIL loop_last d=%0d got=%0d exp=16", d, lastcyc[d]); end
    end
  endtask

  task automatic test_random;
    for (int c = 0; c < 700; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 1) != 0);
      case ($urandom_range(0, 5))
        0:       in_D = 16'h0000;
        1:       in_D = 16'd1 << $urandom_range(0, 15);
        2:       in_D = 16'hFFFF;
        default: in_D = 16'($urandom);
      endcase
      if (c >= 660) begin out_ready = 1'b1; in_valid = 1'b0; end
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        total++;
        if (obs_vec(d) !== exp_vec(d)) begin
          bad++;
          $display("FAIL random d=%0d cyc=%0d got=%h exp=%h", d, c, obs_vec(d), exp_vec(d));
        end
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset;
    test_single;
    test_multibit;
    test_backpressure;
    test_zero;
    test_reset_loopback;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
